// File: rtl/clz_32_if.sv
// clz_32_if: operand/result bundle for the leading-zero counter.
interface clz_32_if;
   logic [31:0] in;
   logic        in_valid;
   logic [5:0]  out;
   logic [5:0]  out_q;
   logic        out_valid;
   modport master (output in, in_valid, input out, out_q, out_valid);
   modport slave (input in, in_valid, output out, out_q, out_valid);
endinterface

// File: rtl/clz_32.sv
// clz_32: 32-bit leading-zero count as a 2-bit-leaf merge tree, plus a registered copy.
module clz_32_merge #(
   parameter int K = 2
) (
   input  logic [K-1:0] h,
   input  logic [K-1:0] l,
   output logic [K:0]   c
);
   localparam logic [K:0] HALF = {1'b0, 1'b1, {(K-1){1'b0}}};
   // top bit of a half count is set only when that half is all zero
   assign c = h[K-1] ? {1'b0, l} + HALF : {1'b0, h};
endmodule

module clz_32 (
   input logic     clk,
   input logic     rst,
   clz_32_if.slave bus
);
   logic [1:0] c1 [16];
   logic [2:0] c2 [8];
   logic [3:0] c3 [4];
   logic [4:0] c4 [2];
   logic [5:0] cnt;
   logic [5:0] out_q, out_d;
   logic       out_valid_q, out_valid_d;
   for (genvar i = 0; i < 16; i++) begin : g_l1
      assign c1[i] = bus.in[2*i+1] ? 2'd0 : bus.in[2*i] ? 2'd1 : 2'd2;
   end
   for (genvar i = 0; i < 8; i++) begin : g_l2
      clz_32_merge #(.K(2)) u_m (.h(c1[2*i+1]), .l(c1[2*i]), .c(c2[i]));
   end
   for (genvar i = 0; i < 4; i++) begin : g_l3
      clz_32_merge #(.K(3)) u_m (.h(c2[2*i+1]), .l(c2[2*i]), .c(c3[i]));
   end
   for (genvar i = 0; i < 2; i++) begin : g_l4
      clz_32_merge #(.K(4)) u_m (.h(c3[2*i+1]), .l(c3[2*i]), .c(c4[i]));
   end
   clz_32_merge #(.K(5)) u_top (.h(c4[1]), .l(c4[0]), .c(cnt));
   always_comb begin
      out_d       = bus.in_valid ? cnt : out_q;
      out_valid_d = bus.in_valid;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end
   assign bus.out       = cnt;
   assign bus.out_q     = out_q;
   assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_clz_32.sv
// tb_clz_32: directed and random checks of clz_32 against an MSB-scan reference.
module tb_clz_32;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   logic [5:0] exp_q;
   logic       exp_v;
   clz_32_if bus ();
   clz_32 dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;

   function automatic int model(input logic [31:0] v);
      for (int i = 31; i >= 0; i--) if (v[i]) return 31 - i;
      return 32;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] v, input logic vld);
      @(posedge clk);
      #2;
      bus.in       = v;
      bus.in_valid = vld;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q <= '0;
         exp_v <= 1'b0;
      end else begin
         exp_v <= bus.in_valid;
         if (bus.in_valid) exp_q <= 6'(model(bus.in));
      end
   end

   always @(negedge clk) begin
      chk("out_vs_model", 32'(bus.out), 32'(model(bus.in)));
      chk("out_q_vs_model", 32'(bus.out_q), 32'(exp_q));
      chk("out_valid_vs_model", 32'(bus.out_valid), 32'(exp_v));
   end

   initial begin
      logic [31:0] v;
      bus.in       = '0;
      bus.in_valid = 1'b0;
      #3;
      chk("reset_out_q", 32'(bus.out_q), 0);
      chk("reset_out_valid", 32'(bus.out_valid), 0);
      chk("reset_out_zero", 32'(bus.out), 32);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         v = 32'd1 << i;
         drive(v, 1'b0);
         #1 chk($sformatf("walk1_%0d", i), 32'(bus.out), 32'(31 - i));
      end
      drive(32'hFFFF_FFFF, 1'b0); #1 chk("all_ones", 32'(bus.out), 0);
      drive(32'h0000_FFFF, 1'b0); #1 chk("low_half", 32'(bus.out), 16);
      drive(32'h0001_0000, 1'b0); #1 chk("bit16", 32'(bus.out), 15);
      drive(32'h0000_8001, 1'b0); #1 chk("h8001", 32'(bus.out), 16);
      drive(32'h0, 1'b1);
      drive(32'h0, 1'b0);
      chk("zero_q", 32'(bus.out_q), 32);
      chk("zero_v", 32'(bus.out_valid), 1);
      drive(32'h8000_0000, 1'b1);
      drive(32'h0000_0001, 1'b1);
      chk("b2b_q0", 32'(bus.out_q), 0);
      chk("b2b_v0", 32'(bus.out_valid), 1);
      drive(32'h0, 1'b1);
      chk("b2b_q1", 32'(bus.out_q), 31);
      chk("b2b_v1", 32'(bus.out_valid), 1);
      drive(32'h0, 1'b0);
      chk("b2b_q2", 32'(bus.out_q), 32);
      chk("b2b_v2", 32'(bus.out_valid), 1);
      drive(32'h0, 1'b0);
      chk("hold_q", 32'(bus.out_q), 32);
      chk("hold_v", 32'(bus.out_valid), 0);
      drive(32'h0000_FFFF, 1'b1);
      drive(32'h0000_1234, 1'b1);
      chk("pre_rst_q", 32'(bus.out_q), 16);
      #1 rst = 1'b1;
      #1;
      chk("async_rst_q", 32'(bus.out_q), 0);
      chk("async_rst_v", 32'(bus.out_valid), 0);
      chk("rst_out_tracks", 32'(bus.out), 19);
      bus.in = 32'h0;
      #1 chk("rst_out_zero", 32'(bus.out), 32);
      @(posedge clk);
      #2 bus.in_valid = 1'b0;
      @(negedge clk);
      #1 rst = 1'b0;
      drive(32'h0000_0000, 1'b0);
      chk("post_rst_v", 32'(bus.out_valid), 0);
      drive(32'h0001_0000, 1'b1);
      drive(32'h0, 1'b0);
      chk("post_rst_q", 32'(bus.out_q), 15);
      chk("post_rst_first_v", 32'(bus.out_valid), 1);
      for (int n = 0; n < 10000; n++) begin
         v = $urandom;
         if (n % 4 == 1) v = v >> $urandom_range(31, 0);
         drive(v, 1'($urandom_range(1, 0)));
      end
      drive(32'h0, 1'b0);
      @(posedge clk);
      #6;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/clz_32.md
CLZ_32 -- requirements
Module: clz_32

Interface
REQ-001 Parameters: none; widths fixed at 32-bit input, 6-bit count.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in  input  32  operand whose leading zeros are counted; bit 31 is MSB.
REQ-005 in_valid  input  1  qualifies in for the registered path.
REQ-006 out  output  6  combinational leading-zero count of in, range 0..32.
REQ-007 out_q  output  6  registered leading-zero count.
REQ-008 out_valid  output  1  high when out_q holds a result.

Function
REQ-009 out SHALL equal the number of consecutive 0 bits in in, starting at bit 31 and counting down to the first 1 bit.
REQ-010 out SHALL be 32 (6'b100000) when in == 0; out[5] SHALL be 1 only in that case.
REQ-011 When in != 0, out SHALL be 31 - (index of the highest set bit), range 0..31.
REQ-012 out SHALL be purely combinational with zero-cycle latency, independent of clk, rst and in_valid; parent 64-bit counters use it combinationally.
REQ-013 Structure: hierarchical tree; count each 16-bit half, then combine.
  - high-half count saturated (all zero): result = 16 + low-half count.
  - otherwise: result = high-half count.
  - 16-bit halves SHALL be built recursively the same way down to 2-bit leaves.
  - no priority-encoder loop over all 32 bits.
REQ-014 Combining arithmetic SHALL be zero-extended by one bit at each level, so no overflow occurs; the all-zero result is exactly 32.
REQ-015 On each rising clk edge with in_valid = 1, out_q SHALL load the value out had for that in, and out_valid SHALL be set to 1 (latency 1 cycle).
REQ-016 On a rising edge with in_valid = 0, out_q SHALL hold its value and out_valid SHALL be set to 0.
REQ-017 No backpressure: a new in_valid sample every cycle SHALL be accepted, with full throughput of 1 result per cycle.
REQ-018 X-free: out SHALL be fully defined for every 32-bit in value.

Reset
REQ-019 While rst = 1, out_q SHALL be 0 and out_valid SHALL be 0, asynchronously and without waiting for a clk edge.
REQ-020 Reset asserted mid-stream SHALL discard any pending sample; the first valid result after rst falls SHALL appear one cycle after the first in_valid.
REQ-021 rst SHALL NOT affect out (combinational path).

Verification
REQ-022 in = 32'h0000_0000 -> out = 32 (6'b100000); with in_valid pulsed, out_q = 32 and out_valid = 1 one cycle later.
REQ-023 in = 1 << i for i = 0..31 (walking one) -> out = 31 - i for every i, including i = 31 (out = 0) and i = 0 (out = 31).
REQ-024 in = 32'hFFFF_FFFF -> out = 0; in = 32'h0000_FFFF -> out = 16; in = 32'h0001_0000 -> out = 15; in = 32'h0000_8001 -> out = 16.
REQ-025 Back-to-back in_valid for 3 cycles with 32'h8000_0000, 32'h0000_0001, 32'h0 -> out_q sequence 0, 31, 32 each one cycle after its input; out_valid = 1 throughout, then 0 after in_valid drops while out_q holds 32.
REQ-026 Assert rst asynchronously between clk edges while out_valid = 1 -> out_q = 0 and out_valid = 0 immediately, while out still tracks in.
REQ-027 Random 32-bit in (≥10k vectors) compared against a behavioural scan-from-MSB model, for both out and out_q.
